line_rasterizer: RTL and testbench
==================================

# line_rasterizer

Hardware line-drawing engine between the CPU core and the frame-buffer memory (320×240, 3-bit colour). The CPU issues one line command (two endpoints and a colour) over a valid/ready handshake. The block walks the line with integer Bresenham at one pixel per clock and drives the memory write port, which frees the core from per-pixel store loops. Pixels outside the canvas are clipped (not written); stepping continues.

## Interface

Parameters:
- `IMAGE_WIDTH`, 320, canvas width in pixels
- `IMAGE_HEIGHT`, 240, canvas height in pixels
- `COLOR_BITS`, 3, colour code width
- `X_BITS`, 9, x coordinate width
- `Y_BITS`, 8, y coordinate width

Ports:
- Clocking: one clock; reset is asynchronous and active-high.
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-high reset
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  block can accept a command
- `cmd_x0`, `cmd_x1`  in  `X_BITS`  endpoint x coordinates, unsigned
- `cmd_y0`, `cmd_y1`  in  `Y_BITS`  endpoint y coordinates, unsigned
- `cmd_color`  in  `COLOR_BITS`  line colour
- `XWrite`  out  `X_BITS`  frame-buffer write x
- `YWrite`  out  `Y_BITS`  frame-buffer write y
- `writeValueMemory`  out  `COLOR_BITS`  frame-buffer write data
- `writeEnable`  out  1  frame-buffer write strobe
- `busy`  out  1  a command is in flight
- `done`  out  1  one-cycle pulse when a line completes

## Operation

- **States:**
  - IDLE → SETUP on `cmd_valid && cmd_ready`.
  - SETUP → DRAW, unconditionally.
  - DRAW → DONE after the endpoint pixel is emitted.
  - DONE → IDLE, unconditionally.
- **Ready and busy:** `cmd_ready` = (state == IDLE) and is combinational. `busy` = !IDLE.
- **Capture:** command fields are registered on acceptance. Input changes after acceptance are ignored.
- **SETUP computes:**
  - `dx = |x1−x0|`
  - `dy = −|y1−y0|`
  - `sx = x1≥x0 ? +1 : −1`
  - `sy = y1≥y0 ? +1 : −1`
  - `err = dx+dy`
  - Initialises (x,y) = (x0,y0).
- **Signed widths:** dx, dy are 11 bits; err is 12 bits; e2 = 2·err is 13 bits. No overflow is possible for the given coordinate ranges.
- **Each DRAW cycle:**
  - Present (x,y,colour) on the write port.
  - `writeEnable` = (x < IMAGE_WIDTH && y < IMAGE_HEIGHT).
  - If (x,y) == (x1,y1), go to DONE.
  - Otherwise, with e2 taken from the current err: if e2 ≥ dy then err += dy and x += sx; if e2 ≤ dx then err += dx and y += sy. Both updates may apply in the same cycle, and err accumulates both.
- **Pixel count:** N = max(dx, −dy) + 1. Degenerate command (x0,y0) == (x1,y1) gives N = 1.
- **DONE:** `done` = 1 for exactly one cycle. `writeEnable` = 0.
- **Reset:** asynchronous and immediate; aborts any line with no `done` pulse.
- **Reset values:** state IDLE, `writeEnable` 0, `XWrite`/`YWrite`/`writeValueMemory` 0, `busy` 0, `done` 0, `cmd_ready` 1. No command is accepted while `reset` is high.

## Timing

- **Outputs:** all write-port outputs, `done` and `busy` are registered.
- **Latency:** handshake at edge E0 → SETUP in the cycle after E0 → first pixel on the write port in the 2nd cycle after E0.
- **Pixel stream:** N pixels on N consecutive cycles with no bubbles.
- **Completion:** `done` is high in the cycle after the last pixel. `cmd_ready` returns high the following cycle.
- **Throughput:** per-command occupancy is N+3 cycles.
- **Back-to-back commands:** the earliest next acceptance is the first IDLE cycle.

## Structure

- **Package `asip_gfx_pkg`:**
  - IMAGE_WIDTH, IMAGE_HEIGHT, COLOR_BITS, X_BITS, Y_BITS constants
  - `raster_state_t` enum (IDLE, SETUP, DRAW, DONE)
  - `line_cmd_t` struct (x0, y0, x1, y1, color)
- **Sub-module `line_step`:** purely combinational. Takes (x, y, err, dx, dy, sx, sy) and returns next (x, y, err) plus `at_end`. The FSM and registers live in `line_rasterizer`.

## Test plan

- **Horizontal line:** (0,0)→(3,0), colour 5 → writes (0,0),(1,0),(2,0),(3,0) on 4 consecutive cycles with data 5; first write 2 cycles after the handshake; `done` one cycle after (3,0).
- **Reversed steep line:** (10,10)→(7,14) → exactly (10,10),(9,11),(8,12),(8,13),(7,14); `done` then `cmd_ready` = 1.
- **Single point:** (319,239)→(319,239), colour 7 → one write, `done` pulse, total busy time 4 cycles.
- **Clipping:** (318,5)→(321,5) → 4 DRAW cycles; `writeEnable` high only for x = 318 and 319, low for 320 and 321; `done` still pulses.
- **Backpressure:** hold `cmd_valid` and change fields mid-line → no acceptance while `busy`; the first line is drawn with the original fields; the second command is accepted in the first IDLE cycle.
- **Reset mid-line:** 10-pixel line with `reset` raised during the 3rd pixel → `writeEnable` drops in the same cycle, `busy` = 0, no `done`; a subsequent command draws correctly.

Source files
------------

// File: rtl/asip_gfx_pkg.sv
// Shared definitions for the graphics blocks of the ASIP.
// Contents:
//   - canvas size and colour/coordinate widths
//   - widths of the signed Bresenham terms (dx/dy, err, e2)
//   - raster_state_t : line_rasterizer FSM states
//   - line_cmd_t     : one captured line command (two endpoints and a colour)
package asip_gfx_pkg;

    localparam int IMAGE_WIDTH  = 320;
    localparam int IMAGE_HEIGHT = 240;
    localparam int COLOR_BITS   = 3;
    localparam int X_BITS       = 9;
    localparam int Y_BITS       = 8;

    // Signed Bresenham terms: |dx| <= 511 fits 11 bits, err = dx + dy fits 12,
    // and e2 = 2*err fits 13, so none of them can overflow.
    localparam int D_BITS   = 11;
    localparam int ERR_BITS = 12;
    localparam int E2_BITS  = 13;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        DRAW  = 2'd2,
        DONE  = 2'd3
    } raster_state_t;

    typedef struct packed {
        logic [X_BITS-1:0]     x0;
        logic [Y_BITS-1:0]     y0;
        logic [X_BITS-1:0]     x1;
        logic [Y_BITS-1:0]     y1;
        logic [COLOR_BITS-1:0] color;
    } line_cmd_t;

endpackage

// File: rtl/line_step.sv
// One Bresenham step, purely combinational.
// Inputs : current pixel (x_i, y_i), error term err_i, deltas dx_i (>= 0) and
//          dy_i (<= 0), step directions sx_neg_i / sy_neg_i (1 = decrement),
//          line endpoint (x1_i, y1_i).
// Outputs: next pixel (x_o, y_o), next error err_o, and at_end_o which is set
//          when the current pixel is the endpoint.
module line_step
    import asip_gfx_pkg::*;
(
    input  logic [X_BITS-1:0]          x_i,
    input  logic [Y_BITS-1:0]          y_i,
    input  logic signed [ERR_BITS-1:0] err_i,
    input  logic signed [D_BITS-1:0]   dx_i,
    input  logic signed [D_BITS-1:0]   dy_i,
    input  logic                       sx_neg_i,
    input  logic                       sy_neg_i,
    input  logic [X_BITS-1:0]          x1_i,
    input  logic [Y_BITS-1:0]          y1_i,
    output logic [X_BITS-1:0]          x_o,
    output logic [Y_BITS-1:0]          y_o,
    output logic signed [ERR_BITS-1:0] err_o,
    output logic                       at_end_o
);

    logic signed [E2_BITS-1:0] e2;
    logic                      step_x;
    logic                      step_y;

    always_comb begin
        // Appending a zero to a 12-bit signed value gives exactly 2*err in 13 bits.
        e2     = {err_i, 1'b0};
        step_x = (e2 >= E2_BITS'(dy_i));
        step_y = (e2 <= E2_BITS'(dx_i));

        // Both moves may apply in one cycle; err then absorbs dy and dx together.
        err_o = err_i;
        if (step_x) err_o = err_o + ERR_BITS'(dy_i);
        if (step_y) err_o = err_o + ERR_BITS'(dx_i);

        x_o = x_i;
        if (step_x) x_o = sx_neg_i ? (x_i - X_BITS'(1)) : (x_i + X_BITS'(1));
        y_o = y_i;
        if (step_y) y_o = sy_neg_i ? (y_i - Y_BITS'(1)) : (y_i + Y_BITS'(1));

        at_end_o = (x_i == x1_i) && (y_i == y1_i);
    end

endmodule

// File: rtl/line_rasterizer.sv
// Line-drawing engine feeding the frame-buffer write port.
// Accepts one line command per valid/ready handshake, walks it with integer
// Bresenham at one pixel per clock and strobes writeEnable for on-canvas pixels.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   cmd_valid/cmd_ready   command handshake; transfer when both are high on a
//                         rising edge. cmd_ready is high exactly in IDLE.
//   cmd_x0/y0/x1/y1       endpoints (unsigned), cmd_color line colour
//   XWrite/YWrite         current pixel, writeValueMemory its colour
//   writeEnable           high when the presented pixel lies on the canvas
//   busy                  high from SETUP through DONE
//   done                  one-cycle pulse after the last pixel
module line_rasterizer #(
    parameter int IMAGE_WIDTH  = asip_gfx_pkg::IMAGE_WIDTH,
    parameter int IMAGE_HEIGHT = asip_gfx_pkg::IMAGE_HEIGHT,
    parameter int COLOR_BITS   = asip_gfx_pkg::COLOR_BITS,
    parameter int X_BITS       = asip_gfx_pkg::X_BITS,
    parameter int Y_BITS       = asip_gfx_pkg::Y_BITS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [X_BITS-1:0]     cmd_x0,
    input  logic [Y_BITS-1:0]     cmd_y0,
    input  logic [X_BITS-1:0]     cmd_x1,
    input  logic [Y_BITS-1:0]     cmd_y1,
    input  logic [COLOR_BITS-1:0] cmd_color,
    output logic [X_BITS-1:0]     XWrite,
    output logic [Y_BITS-1:0]     YWrite,
    output logic [COLOR_BITS-1:0] writeValueMemory,
    output logic                  writeEnable,
    output logic                  busy,
    output logic                  done
);
    import asip_gfx_pkg::*;

    localparam logic [X_BITS-1:0] X_LIM = X_BITS'(IMAGE_WIDTH);
    localparam logic [Y_BITS-1:0] Y_LIM = Y_BITS'(IMAGE_HEIGHT);

    raster_state_t               state_q;
    line_cmd_t                   cmd_q;
    logic [X_BITS-1:0]           x_q;
    logic [Y_BITS-1:0]           y_q;
    logic signed [ERR_BITS-1:0]  err_q;
    logic signed [D_BITS-1:0]    dx_q;
    logic signed [D_BITS-1:0]    dy_q;
    logic                        sx_neg_q;
    logic                        sy_neg_q;
    logic                        we_q;
    logic                        busy_q;
    logic                        done_q;

    logic [X_BITS-1:0]           adx;
    logic [Y_BITS-1:0]           ady;
    logic signed [D_BITS-1:0]    dx_init;
    logic signed [D_BITS-1:0]    dy_init;
    logic signed [ERR_BITS-1:0]  err_init;

    logic [X_BITS-1:0]           x_d;
    logic [Y_BITS-1:0]           y_d;
    logic signed [ERR_BITS-1:0]  err_d;
    logic                        at_end;

    assign cmd_ready        = (state_q == IDLE);
    assign XWrite           = x_q;
    assign YWrite           = y_q;
    assign writeValueMemory = cmd_q.color;
    assign writeEnable      = we_q;
    assign busy             = busy_q;
    assign done             = done_q;

    // Setup terms derived from the captured command.
    always_comb begin
        adx      = (cmd_q.x1 >= cmd_q.x0) ? (cmd_q.x1 - cmd_q.x0) : (cmd_q.x0 - cmd_q.x1);
        ady      = (cmd_q.y1 >= cmd_q.y0) ? (cmd_q.y1 - cmd_q.y0) : (cmd_q.y0 - cmd_q.y1);
        dx_init  = D_BITS'(adx);
        dy_init  = -D_BITS'(ady);
        err_init = ERR_BITS'(dx_init) + ERR_BITS'(dy_init);
    end

    line_step u_step (
        .x_i      (x_q),
        .y_i      (y_q),
        .err_i    (err_q),
        .dx_i     (dx_q),
        .dy_i     (dy_q),
        .sx_neg_i (sx_neg_q),
        .sy_neg_i (sy_neg_q),
        .x1_i     (cmd_q.x1),
        .y1_i     (cmd_q.y1),
        .x_o      (x_d),
        .y_o      (y_d),
        .err_o    (err_d),
        .at_end_o (at_end)
    );

    // The write port always shows (x_q, y_q); the registers below load the
    // next pixel so each DRAW cycle presents exactly one pixel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cmd_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            err_q    <= '0;
            dx_q     <= '0;
            dy_q     <= '0;
            sx_neg_q <= 1'b0;
            sy_neg_q <= 1'b0;
            we_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        cmd_q   <= '{x0: cmd_x0, y0: cmd_y0, x1: cmd_x1,
                                     y1: cmd_y1, color: cmd_color};
                        busy_q  <= 1'b1;
                        state_q <= SETUP;
                    end
                end
                SETUP: begin
                    x_q      <= cmd_q.x0;
                    y_q      <= cmd_q.y0;
                    dx_q     <= dx_init;
                    dy_q     <= dy_init;
                    err_q    <= err_init;
                    sx_neg_q <= (cmd_q.x1 < cmd_q.x0);
                    sy_neg_q <= (cmd_q.y1 < cmd_q.y0);
                    we_q     <= (cmd_q.x0 < X_LIM) && (cmd_q.y0 < Y_LIM);
                    state_q  <= DRAW;
                end
                DRAW: begin
                    if (at_end) begin
                        we_q    <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        x_q   <= x_d;
                        y_q   <= y_d;
                        err_q <= err_d;
                        we_q  <= (x_d < X_LIM) && (y_d < Y_LIM);
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_line_rasterizer.sv
// Bench for line_rasterizer: scenario tasks push the expected pixel stream
// ({writeEnable, x, y, colour}) into exp_q when a command is driven and pop it
// one entry per DRAW cycle while the DUT draws. Outputs are sampled on the
// falling edge; inputs change on the falling edge or 1 ns after a rising edge.
module tb_line_rasterizer;

    logic       clk;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [8:0] cmd_x0;
    logic [7:0] cmd_y0;
    logic [8:0] cmd_x1;
    logic [7:0] cmd_y1;
    logic [2:0] cmd_color;
    logic [8:0] XWrite;
    logic [7:0] YWrite;
    logic [2:0] writeValueMemory;
    logic       writeEnable;
    logic       busy;
    logic       done;

    logic [20:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    line_rasterizer dut (
        .clk              (clk),
        .reset            (reset),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_x0           (cmd_x0),
        .cmd_y0           (cmd_y0),
        .cmd_x1           (cmd_x1),
        .cmd_y1           (cmd_y1),
        .cmd_color        (cmd_color),
        .XWrite           (XWrite),
        .YWrite           (YWrite),
        .writeValueMemory (writeValueMemory),
        .writeEnable      (writeEnable),
        .busy             (busy),
        .done             (done)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- expected-stream helpers ----------------
    function automatic logic [20:0] pix(input logic we, input int x, input int y, input int c);
        logic [8:0] xv;
        logic [7:0] yv;
        logic [2:0] cv;
        xv = x[8:0];
        yv = y[7:0];
        cv = c[2:0];
        return {we, xv, yv, cv};
    endfunction

    // Reference Bresenham on plain integers; returns the pixel count.
    function automatic int push_model(input int x0, input int y0, input int x1, input int y1, input int c);
        int x, y, ddx, ddy, stx, sty, e, e2, n;
        ddx = (x1 > x0) ? x1 - x0 : x0 - x1;
        ddy = (y1 > y0) ? y0 - y1 : y1 - y0;
        stx = (x1 >= x0) ? 1 : -1;
        sty = (y1 >= y0) ? 1 : -1;
        e = ddx + ddy;
        x = x0;
        y = y0;
        n = 0;
        forever begin
            exp_q.push_back(pix((x < 320) && (y < 240), x, y, c));
            n++;
            if (x == x1 && y == y1) break;
            e2 = 2 * e;
            if (e2 >= ddy) begin e = e + ddy; x = x + stx; end
            if (e2 <= ddx) begin e = e + ddx; y = y + sty; end
        end
        return n;
    endfunction

    // ---------------- driver tasks ----------------
    // Presents a command and returns 1 ns after the accepting edge; cmd_valid stays high.
    task automatic drive_cmd(input int x0, input int y0, input int x1, input int y1, input int c);
        int waited;
        waited = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_x0 = x0[8:0];
        cmd_y0 = y0[7:0];
        cmd_x1 = x1[8:0];
        cmd_y1 = y1[7:0];
        cmd_color = c[2:0];
        while (cmd_ready !== 1'b1 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL handshake_timeout: cmd_ready=%b, required 1 within 100 cycles", cmd_ready);
        end
        @(posedge clk);
        #1;
    endtask

    // Called right after the accepting edge: SETUP cycle, n pixels, DONE, IDLE.
    task automatic drain_line(input int n, input string name);
        logic [20:0] exp, got;
        @(negedge clk);
        checks++;
        if (writeEnable !== 1'b0 || busy !== 1'b1 || cmd_ready !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s_setup: we=%b busy=%b ready=%b done=%b, required 0 1 0 0",
                     name, writeEnable, busy, cmd_ready, done);
        end
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL %s_queue: expected queue empty at pixel %0d", name, i);
                break;
            end
            exp = exp_q.pop_front();
            got = {writeEnable, XWrite, YWrite, writeValueMemory};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL %s_pixel%0d: got we=%b x=%0d y=%0d c=%0d, required we=%b x=%0d y=%0d c=%0d",
                         name, i, got[20], got[19:11], got[10:3], got[2:0],
                         exp[20], exp[19:11], exp[10:3], exp[2:0]);
            end
            checks++;
            if (done !== 1'b0 || busy !== 1'b1 || cmd_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s_draw_flags%0d: done=%b busy=%b ready=%b, required 0 1 0",
                         name, i, done, busy, cmd_ready);
            end
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || writeEnable !== 1'b0 || busy !== 1'b1 || cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s_done: done=%b we=%b busy=%b ready=%b, required 1 0 1 0",
                     name, done, writeEnable, busy, cmd_ready);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1 || writeEnable !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle: done=%b busy=%b ready=%b we=%b, required 0 0 1 0",
                     name, done, busy, cmd_ready, writeEnable);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_leftover: %0d expected pixels not drawn, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        cmd_valid = 1'b1;
        cmd_x0 = 9'd1; cmd_y0 = 8'd1; cmd_x1 = 9'd2; cmd_y1 = 8'd2; cmd_color = 3'd1;
        repeat (3) @(negedge clk);
        checks++;
        if ({writeEnable, XWrite, YWrite, writeValueMemory, busy, done, cmd_ready} !== {1'b0, 9'd0, 8'd0, 3'd0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_values: we=%b x=%0d y=%0d c=%0d busy=%b done=%b ready=%b, required 0 0 0 0 0 0 1",
                     writeEnable, XWrite, YWrite, writeValueMemory, busy, done, cmd_ready);
        end
        cmd_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_no_accept: busy=%b ready=%b, required 0 1", busy, cmd_ready);
        end
    endtask

    task automatic test_horizontal();
        for (int i = 0; i < 4; i++) exp_q.push_back(pix(1'b1, i, 0, 5));
        drive_cmd(0, 0, 3, 0, 5);
        cmd_valid = 1'b0;
        drain_line(4, "horizontal");
    endtask

    task automatic test_steep_reversed();
        exp_q.push_back(pix(1'b1, 10, 10, 2));
        exp_q.push_back(pix(1'b1, 9, 11, 2));
        exp_q.push_back(pix(1'b1, 8, 12, 2));
        exp_q.push_back(pix(1'b1, 8, 13, 2));
        exp_q.push_back(pix(1'b1, 7, 14, 2));
        drive_cmd(10, 10, 7, 14, 2);
        cmd_valid = 1'b0;
        drain_line(5, "steep");
    endtask

    task automatic test_single_point();
        int occ;
        exp_q.push_back(pix(1'b1, 319, 239, 7));
        drive_cmd(319, 239, 319, 239, 7);
        cmd_valid = 1'b0;
        // Occupancy counts the accepting IDLE cycle plus every cycle until ready returns.
        occ = 1;
        @(negedge clk);
        while (cmd_ready !== 1'b1 && occ < 50) begin
            occ++;
            if (writeEnable === 1'b1 && exp_q.size() != 0) begin
                checks++;
                if ({XWrite, YWrite, writeValueMemory} !== exp_q[0][19:0]) begin
                    errors++;
                    $display("FAIL single_pixel: x=%0d y=%0d c=%0d, required 319 239 7",
                             XWrite, YWrite, writeValueMemory);
                end
                void'(exp_q.pop_front());
            end
            @(negedge clk);
        end
        checks++;
        if (occ != 4) begin
            errors++;
            $display("FAIL single_occupancy: %0d cycles, required 4", occ);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL single_written: pixel never written");
            exp_q.delete();
        end
    endtask

    task automatic test_single_point_stream();
        exp_q.push_back(pix(1'b1, 0, 0, 4));
        drive_cmd(0, 0, 0, 0, 4);
        cmd_valid = 1'b0;
        drain_line(1, "single");
    endtask

    task automatic test_clipping();
        exp_q.push_back(pix(1'b1, 318, 5, 6));
        exp_q.push_back(pix(1'b1, 319, 5, 6));
        exp_q.push_back(pix(1'b0, 320, 5, 6));
        exp_q.push_back(pix(1'b0, 321, 5, 6));
        drive_cmd(318, 5, 321, 5, 6);
        cmd_valid = 1'b0;
        drain_line(4, "clip_x");
        // Vertical clip across the bottom edge, drawn upward.
        exp_q.push_back(pix(1'b0, 30, 241, 1));
        exp_q.push_back(pix(1'b0, 30, 240, 1));
        exp_q.push_back(pix(1'b1, 30, 239, 1));
        drive_cmd(30, 241, 30, 239, 1);
        cmd_valid = 1'b0;
        drain_line(3, "clip_y");
    endtask

    task automatic test_backpressure();
        int na, nb;
        na = push_model(20, 20, 24, 22, 3);
        drive_cmd(20, 20, 24, 22, 3);
        // Keep valid high with new fields; they must not disturb the line in flight.
        cmd_x0 = 9'd100; cmd_y0 = 8'd100; cmd_x1 = 9'd97; cmd_y1 = 8'd101; cmd_color = 3'd6;
        drain_line(na, "bp_first");
        nb = push_model(100, 100, 97, 101, 6);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL bp_accept_first_idle: busy=%b, required 1", busy);
        end
        drain_line(nb, "bp_second");
    endtask

    task automatic test_reset_midline();
        int done_seen;
        drive_cmd(0, 50, 9, 50, 2);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);  // SETUP, pixel 0, pixel 1
        @(negedge clk);             // pixel 2
        checks++;
        if (writeEnable !== 1'b1 || XWrite !== 9'd2 || YWrite !== 8'd50) begin
            errors++;
            $display("FAIL midline_pixel2: we=%b x=%0d y=%0d, required 1 2 50", writeEnable, XWrite, YWrite);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (writeEnable !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL midline_reset_async: we=%b busy=%b done=%b ready=%b, required 0 0 0 1",
                     writeEnable, busy, done, cmd_ready);
        end
        @(negedge clk);
        reset = 1'b0;
        done_seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1 || writeEnable === 1'b1) done_seen++;
        end
        checks++;
        if (done_seen != 0) begin
            errors++;
            $display("FAIL midline_aborted: %0d cycles with done/busy/we after reset, required 0", done_seen);
        end
        exp_q.push_back(pix(1'b1, 5, 5, 3));
        exp_q.push_back(pix(1'b1, 6, 6, 3));
        exp_q.push_back(pix(1'b1, 7, 7, 3));
        drive_cmd(5, 5, 7, 7, 3);
        cmd_valid = 1'b0;
        drain_line(3, "after_reset");
    endtask

    task automatic test_random_lines();
        int x0, y0, x1, y1, c, n;
        for (int k = 0; k < 8; k++) begin
            x0 = $urandom_range(0, 340);
            y0 = $urandom_range(0, 255);
            x1 = $urandom_range(0, 340);
            y1 = $urandom_range(0, 255);
            c  = $urandom_range(0, 7);
            n = push_model(x0, y0, x1, y1, c);
            drive_cmd(x0, y0, x1, y1, c);
            cmd_valid = 1'b0;
            drain_line(n, $sformatf("rand%0d", k));
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        reset = 1'b1;
        cmd_valid = 1'b0;
        cmd_x0 = '0; cmd_y0 = '0; cmd_x1 = '0; cmd_y1 = '0; cmd_color = '0;
        test_reset();
        test_horizontal();
        test_steep_reversed();
        test_single_point();
        test_single_point_stream();
        test_clipping();
        test_backpressure();
        test_reset_midline();
        test_random_lines();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
